// File: rtl/bdi_decompressor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bdi_pkg
//  Description : Shared types and constants for the BDI decompressor:
//                tag encoding, line/chunk widths, per-tag base/delta/payload
//                sizes and the decompressor FSM state encoding.
//                The optional fastpath is selected by BDI_DEC_FASTPATH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package bdi_pkg;

    localparam int LINE_W  = 256;
    localparam int CHUNK_W = 64;

    typedef enum logic [2:0] {
        TAG_UNC  = 3'd0,
        TAG_B8D1 = 3'd1,
        TAG_B8D2 = 3'd2,
        TAG_B8D4 = 3'd3,
        TAG_B4D1 = 3'd4,
        TAG_B4D2 = 3'd5,
        TAG_B2D1 = 3'd6,
        TAG_ZERO = 3'd7
    } bdi_tag_e;

    // Base / delta widths in bits and total payload sizes per encoding.
    localparam int C_B8D1_BASE_W = 64, C_B8D1_DELTA_W = 8,  C_B8D1_PAY_W = 96;
    localparam int C_B8D2_BASE_W = 64, C_B8D2_DELTA_W = 16, C_B8D2_PAY_W = 128;
    localparam int C_B8D4_BASE_W = 64, C_B8D4_DELTA_W = 32, C_B8D4_PAY_W = 192;
    localparam int C_B4D1_BASE_W = 32, C_B4D1_DELTA_W = 8,  C_B4D1_PAY_W = 96;
    localparam int C_B4D2_BASE_W = 32, C_B4D2_DELTA_W = 16, C_B4D2_PAY_W = 160;
    localparam int C_B2D1_BASE_W = 16, C_B2D1_DELTA_W = 8,  C_B2D1_PAY_W = 144;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } bdi_dec_st_e;

endpackage
`default_nettype wire

// File: rtl/bdi_decompressor_if.sv
`default_nettype none
// ============================================================================
//  Module      : bdi_decompressor_if
//  Description : Valid/ready bus carrying compressed lines in and
//                reconstructed lines out of the BDI decompressor.
//                master : line producer / line consumer side
//                slave  : decompressor side
//  Revision    : 1.0 - initial release
// ============================================================================
interface bdi_decompressor_if;
    import bdi_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_tag;
    logic [LINE_W-1:0]   in_payload;
    logic                out_valid;
    logic                out_ready;
    logic [LINE_W-1:0]   out_line;
    logic [2:0]          out_tag;

    modport master (
        output in_valid, in_tag, in_payload, out_ready,
        input  in_ready, out_valid, out_line, out_tag
    );

    modport slave (
        input  in_valid, in_tag, in_payload, out_ready,
        output in_ready, out_valid, out_line, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/bdi_decompressor_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : bdi_dec_chunk
//  Description : Combinational reconstruction of one 64-bit output chunk
//                from a BDI payload.
//  Ports       : tag_i     - encoding of the latched line
//                payload_i - latched compressed payload (LSB aligned)
//                idx_i     - chunk index 0..3
//                chunk_o   - reconstructed 64-bit chunk
//  Revision    : 1.0 - initial release
// ============================================================================
module bdi_dec_chunk
    import bdi_pkg::*;
(
    input  bdi_tag_e             tag_i,
    input  logic [LINE_W-1:0]    payload_i,
    input  logic [1:0]           idx_i,
    output logic [CHUNK_W-1:0]   chunk_o
);

    // Sign-extend the low w bits of d to 64 bits.
    function automatic logic [63:0] sx(input logic [31:0] d, input int w);
        logic [63:0] r;
        for (int k = 0; k < 64; k++) begin
            r[k] = (k < w) ? d[k] : d[w-1];
        end
        return r;
    endfunction

    int w_idx;
    assign w_idx = int'(idx_i);

    // Word i of the line sits in chunk i*B/64; a chunk holds 64/B words.
    always_comb begin
        chunk_o = '0;
        unique case (tag_i)
            TAG_UNC:  chunk_o = payload_i[w_idx*64 +: 64];
            TAG_ZERO: chunk_o = '0;
            TAG_B8D1: chunk_o = payload_i[63:0]
                              + sx(32'(payload_i[64 + 8*w_idx +: 8]), 8);
            TAG_B8D2: chunk_o = payload_i[63:0]
                              + sx(32'(payload_i[64 + 16*w_idx +: 16]), 16);
            TAG_B8D4: chunk_o = payload_i[63:0]
                              + sx(payload_i[64 + 32*w_idx +: 32], 32);
            TAG_B4D1: begin
                for (int j = 0; j < 2; j++) begin
                    chunk_o[32*j +: 32] = payload_i[31:0]
                        + 32'(sx(32'(payload_i[32 + 8*(2*w_idx + j) +: 8]), 8));
                end
            end
            TAG_B4D2: begin
                for (int j = 0; j < 2; j++) begin
                    chunk_o[32*j +: 32] = payload_i[31:0]
                        + 32'(sx(32'(payload_i[32 + 16*(2*w_idx + j) +: 16]), 16));
                end
            end
            TAG_B2D1: begin
                for (int j = 0; j < 4; j++) begin
                    chunk_o[16*j +: 16] = payload_i[15:0]
                        + 16'(sx(32'(payload_i[16 + 8*(4*w_idx + j) +: 8]), 8));
                end
            end
            default:  chunk_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bdi_decompressor.sv
`default_nettype none
// ============================================================================
//  Module      : bdi_decompressor
//  Description : Sequential Base-Delta-Immediate decompressor. Latches a
//                tagged payload, rebuilds the 256-bit line one 64-bit chunk
//                per cycle, then holds it until the consumer takes it.
//                Optional macro BDI_DEC_FASTPATH_EN: UNC and ZERO lines skip
//                the expand phase and are returned straight from the accept.
//  Ports       : clock   - rising-edge clock
//                reset_n - asynchronous active-low reset
//                bus     - slave side of bdi_decompressor_if (in/out handshakes)
//  Revision    : 1.0 - initial release
// ============================================================================
module bdi_decompressor
    import bdi_pkg::*;
#(
    parameter int LINE_W  = bdi_pkg::LINE_W,
    parameter int CHUNK_W = bdi_pkg::CHUNK_W
)(
    input  logic                    clock,
    input  logic                    reset_n,
    bdi_decompressor_if.slave       bus
);

    bdi_dec_st_e            st_q;
    logic [1:0]             cnt_q;
    bdi_tag_e               tag_q;
    logic [LINE_W-1:0]      payload_q;
    logic [LINE_W-1:0]      line_q;
    logic                   valid_q;
    logic [CHUNK_W-1:0]     chunk_d;

    bdi_dec_chunk u_chunk (
        .tag_i     (tag_q),
        .payload_i (payload_q),
        .idx_i     (cnt_q),
        .chunk_o   (chunk_d)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q      <= ST_IDLE;
            cnt_q     <= 2'd0;
            tag_q     <= TAG_UNC;
            payload_q <= '0;
            line_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        tag_q     <= bdi_tag_e'(bus.in_tag);
                        payload_q <= bus.in_payload;
                        cnt_q     <= 2'd0;
                        line_q    <= '0;
                        st_q      <= ST_EXPAND;
`ifdef BDI_DEC_FASTPATH_EN
                        if (bdi_tag_e'(bus.in_tag) == TAG_UNC) begin
                            line_q  <= bus.in_payload;
                            st_q    <= ST_DONE;
                            valid_q <= 1'b1;
                        end else if (bdi_tag_e'(bus.in_tag) == TAG_ZERO) begin
                            st_q    <= ST_DONE;
                            valid_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_EXPAND: begin
                    line_q[cnt_q*CHUNK_W +: CHUNK_W] <= chunk_d;
                    cnt_q <= cnt_q + 2'd1;
                    // Leave on the last chunk so the counter wrap is never seen.
                    if (cnt_q == 2'd3) begin
                        st_q    <= ST_DONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        st_q    <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (st_q == ST_IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_line  = line_q;
    assign bus.out_tag   = tag_q;

endmodule
`default_nettype wire
